// File: rtl/mips32_alu_pkg.sv
// Shared constants for the MIPS32 execute-stage ALU.
// Operator encodings are the decoder's OPERATOR field values.
package mips32_alu_pkg;

  localparam int WORD_LEN     = 32;
  localparam int OPERATOR_LEN = 4;
  localparam int SHAMT_LEN    = 5;

  localparam logic [OPERATOR_LEN-1:0] OPERATOR_ADD = 4'd0;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SUB = 4'd1;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_AND = 4'd2;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_OR  = 4'd3;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_NOR = 4'd4;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_XOR = 4'd5;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SLA = 4'd6;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SLL = 4'd7;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SRA = 4'd8;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SRL = 4'd9;

  typedef enum logic [1:0] {
    SH_LEFT  = 2'd0,
    SH_LOGIC = 2'd1,
    SH_ARITH = 2'd2
  } shift_mode_e;

  function automatic logic [WORD_LEN-1:0] bit_rev(
    input logic [WORD_LEN-1:0] v
  );
    logic [WORD_LEN-1:0] r;
    for (int i = 0; i < WORD_LEN; i++) begin
      r[i] = v[WORD_LEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mips32_alu_if.sv
// Operand/result bundle between decoder, ALU and write-back.
// Flag signals exist only when ALU_FLAGS_EN is defined.
interface mips32_alu_if;

  logic [mips32_alu_pkg::WORD_LEN-1:0]     OPERAND1;
  logic [mips32_alu_pkg::WORD_LEN-1:0]     OPERAND2;
  logic [mips32_alu_pkg::OPERATOR_LEN-1:0] OPERATOR;
  logic [mips32_alu_pkg::WORD_LEN-1:0]     ALU_OUT;

`ifdef ALU_FLAGS_EN
  logic ZERO;
  logic CARRY;
  logic OVERFLOW;

  modport master (
    output OPERAND1,
    output OPERAND2,
    output OPERATOR,
    input  ALU_OUT,
    input  ZERO,
    input  CARRY,
    input  OVERFLOW
  );

  modport slave (
    input  OPERAND1,
    input  OPERAND2,
    input  OPERATOR,
    output ALU_OUT,
    output ZERO,
    output CARRY,
    output OVERFLOW
  );
`else
  modport master (
    output OPERAND1,
    output OPERAND2,
    output OPERATOR,
    input  ALU_OUT
  );

  modport slave (
    input  OPERAND1,
    input  OPERAND2,
    input  OPERATOR,
    output ALU_OUT
  );
`endif

endinterface

// File: rtl/mips32_alu_shifter.sv
// Combinational 5-stage barrel shifter.
// Left shifts reuse the right-shift stages on a bit-reversed word.
module mips32_alu_shifter
  import mips32_alu_pkg::*;
(
  input  logic [WORD_LEN-1:0]  value_i,
  input  logic [SHAMT_LEN-1:0] amount_i,
  input  shift_mode_e          mode_i,
  output logic [WORD_LEN-1:0]  result_o
);

  logic                is_left;
  logic                fill;
  logic [WORD_LEN-1:0] stage [SHAMT_LEN+1];

  assign is_left  = (mode_i == SH_LEFT);
  assign fill     = (mode_i == SH_ARITH) & value_i[WORD_LEN-1];
  assign stage[0] = is_left ? bit_rev(value_i) : value_i;

  for (genvar k = 0; k < SHAMT_LEN; k++) begin : g_stage
    localparam int S = 2 ** k;
    assign stage[k+1] = amount_i[k]
      ? {{S{fill}}, stage[k][WORD_LEN-1:S]}
      : stage[k];
  end

  assign result_o = is_left
    ? bit_rev(stage[SHAMT_LEN])
    : stage[SHAMT_LEN];

endmodule

// File: rtl/mips32_alu.sv
// Registered 32-bit ALU for the execute stage, one-cycle latency.
// Define ALU_FLAGS_EN to add registered ZERO/CARRY/OVERFLOW outputs.
module mips32_alu
  import mips32_alu_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_N,
  mips32_alu_if.slave  bus
);

  logic [WORD_LEN-1:0]     a;
  logic [WORD_LEN-1:0]     b;
  logic [OPERATOR_LEN-1:0] op;
  logic                    is_sub;
  logic [WORD_LEN-1:0]     b_eff;
  logic [WORD_LEN-1:0]     sum;
  logic [WORD_LEN-1:0]     sh_res;
  shift_mode_e             sh_mode;
  logic [WORD_LEN-1:0]     alu_out_d;
  logic [WORD_LEN-1:0]     alu_out_q;

  assign a      = bus.OPERAND1;
  assign b      = bus.OPERAND2;
  assign op     = bus.OPERATOR;
  assign is_sub = (op == OPERATOR_SUB);
  // Subtract as A + ~B + 1 so one adder serves both ops
  assign b_eff  = is_sub ? ~b : b;

`ifdef ALU_FLAGS_EN
  logic carry_w;
  assign {carry_w, sum} =
    {1'b0, a} + {1'b0, b_eff}
    + {{WORD_LEN{1'b0}}, is_sub};
`else
  assign sum = a + b_eff
    + {{(WORD_LEN-1){1'b0}}, is_sub};
`endif

  always_comb begin
    sh_mode = SH_LEFT;
    unique case (op)
      OPERATOR_SRA: sh_mode = SH_ARITH;
      OPERATOR_SRL: sh_mode = SH_LOGIC;
      default:      sh_mode = SH_LEFT;
    endcase
  end

  mips32_alu_shifter u_shifter (
    .value_i  (a),
    .amount_i (b[SHAMT_LEN-1:0]),
    .mode_i   (sh_mode),
    .result_o (sh_res)
  );

  always_comb begin
    alu_out_d = '0;
    unique case (op)
      OPERATOR_ADD: alu_out_d = sum;
      OPERATOR_SUB: alu_out_d = sum;
      OPERATOR_AND: alu_out_d = a & b;
      OPERATOR_OR:  alu_out_d = a | b;
      OPERATOR_NOR: alu_out_d = ~(a | b);
      OPERATOR_XOR: alu_out_d = a ^ b;
      OPERATOR_SLA: alu_out_d = sh_res;
      OPERATOR_SLL: alu_out_d = sh_res;
      OPERATOR_SRA: alu_out_d = sh_res;
      OPERATOR_SRL: alu_out_d = sh_res;
      default:      alu_out_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_out_q <= '0;
    end else begin
      alu_out_q <= alu_out_d;
    end
  end

  assign bus.ALU_OUT = alu_out_q;

`ifdef ALU_FLAGS_EN
  logic is_arith;
  logic zero_d;
  logic carry_d;
  logic ovf_d;
  logic zero_q;
  logic carry_q;
  logic ovf_q;

  assign is_arith = (op == OPERATOR_ADD) | is_sub;
  assign zero_d   = (alu_out_d == '0);
  assign carry_d  = is_arith & carry_w;
  // Overflow: operands agree in sign but the sum does not
  assign ovf_d    = is_arith
    & (a[WORD_LEN-1] == b_eff[WORD_LEN-1])
    & (sum[WORD_LEN-1] != a[WORD_LEN-1]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ZERO     = zero_q;
  assign bus.CARRY    = carry_q;
  assign bus.OVERFLOW = ovf_q;
`endif

endmodule

// File: tb/tb_mips32_alu.sv
// Directed-vector bench for mips32_alu.
// Flag checks are compiled in only with ALU_FLAGS_EN.
module tb_mips32_alu;
  import mips32_alu_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mips32_alu_if u_if ();

  mips32_alu u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    u_if.OPERATOR = op;
    u_if.OPERAND1 = a;
    u_if.OPERAND2 = b;
  endtask

  task automatic run(
    input string       tag,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] exp
  );
    drive(op, a, b);
    @(posedge clk);
    #1;
    check(tag, u_if.ALU_OUT, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    u_if.OPERATOR = OPERATOR_ADD;
    u_if.OPERAND1 = 32'd7;
    u_if.OPERAND2 = 32'd9;

    #1;
    check("reset_t0", u_if.ALU_OUT, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", u_if.ALU_OUT, 32'd0);
`ifdef ALU_FLAGS_EN
    check("reset_zero", {31'd0, u_if.ZERO}, 32'd0);
    check("reset_carry", {31'd0, u_if.CARRY}, 32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    run("add",  OPERATOR_ADD, 32'd30, 32'd10, 32'd40);
    run("and",  OPERATOR_AND, 32'd30, 32'd10, 32'd10);
    run("nor",  OPERATOR_NOR, 32'd30, 32'd10, 32'hFFFFFFE1);
    run("or",   OPERATOR_OR,  32'd30, 32'd10, 32'd30);
    run("xor",  OPERATOR_XOR, 32'd30, 32'd10, 32'd20);
    run("sub",  OPERATOR_SUB, 32'd30, 32'd10, 32'd20);
    run("sla",  OPERATOR_SLA, 32'd30, 32'd10, 32'd30720);
    run("sra",  OPERATOR_SRA, 32'd30, 32'd10, 32'd0);
    run("sll",  OPERATOR_SLL, 32'd30, 32'd10, 32'd30720);
    run("srl",  OPERATOR_SRL, 32'd30, 32'd10, 32'd0);

    // Mid-stream async reset with a nonzero result held
    run("pre_rst", OPERATOR_ADD, 32'd100, 32'd23, 32'd123);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", u_if.ALU_OUT, 32'd0);
    drive(OPERATOR_XOR, 32'hF0F0F0F0, 32'h0FF00FF0);
    @(posedge clk);
    #1;
    check("rst_hold_edge", u_if.ALU_OUT, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_rst", u_if.ALU_OUT, 32'hFF00FF00);

    run("add_wrap", OPERATOR_ADD,
        32'hFFFFFFFF, 32'd1, 32'd0);
`ifdef ALU_FLAGS_EN
    check("add_wrap_zero", {31'd0, u_if.ZERO}, 32'd1);
    check("add_wrap_carry", {31'd0, u_if.CARRY}, 32'd1);
    check("add_wrap_ovf", {31'd0, u_if.OVERFLOW}, 32'd0);
`endif
    run("sub_wrap", OPERATOR_SUB,
        32'd0, 32'd1, 32'hFFFFFFFF);
`ifdef ALU_FLAGS_EN
    check("sub_wrap_carry", {31'd0, u_if.CARRY}, 32'd0);
    check("sub_wrap_zero", {31'd0, u_if.ZERO}, 32'd0);
`endif
    run("add_ovf", OPERATOR_ADD,
        32'h7FFFFFFF, 32'd1, 32'h80000000);
`ifdef ALU_FLAGS_EN
    check("add_ovf_flag", {31'd0, u_if.OVERFLOW}, 32'd1);
    check("add_ovf_carry", {31'd0, u_if.CARRY}, 32'd0);
`endif
    run("sub_pos", OPERATOR_SUB, 32'd5, 32'd3, 32'd2);
`ifdef ALU_FLAGS_EN
    check("sub_pos_carry", {31'd0, u_if.CARRY}, 32'd1);
`endif
    run("sub_ovf", OPERATOR_SUB,
        32'h80000000, 32'd1, 32'h7FFFFFFF);
`ifdef ALU_FLAGS_EN
    check("sub_ovf_flag", {31'd0, u_if.OVERFLOW}, 32'd1);
`endif

    run("sra_neg", OPERATOR_SRA,
        32'h80000000, 32'd4, 32'hF8000000);
    run("srl_neg", OPERATOR_SRL,
        32'h80000000, 32'd4, 32'h08000000);
    run("sll_amt32", OPERATOR_SLL,
        32'h12345678, 32'h00000020, 32'h12345678);
    run("srl_hi_ign", OPERATOR_SRL,
        32'h12345678, 32'hFFFFFFE4, 32'h01234567);
    run("sll_31", OPERATOR_SLL,
        32'd1, 32'd31, 32'h80000000);
    run("sra_31", OPERATOR_SRA,
        32'h80000000, 32'd31, 32'hFFFFFFFF);
    run("srl_31", OPERATOR_SRL,
        32'h80000000, 32'd31, 32'h00000001);
    run("sla_sign", OPERATOR_SLA,
        32'hC0000001, 32'd1, 32'h80000002);
    run("sra_pos", OPERATOR_SRA,
        32'h70000000, 32'd8, 32'h00700000);
    run("nor_zero", OPERATOR_NOR,
        32'hFFFF0000, 32'h0000FFFF, 32'd0);
`ifdef ALU_FLAGS_EN
    check("nor_zero_flag", {31'd0, u_if.ZERO}, 32'd1);
    check("nor_carry", {31'd0, u_if.CARRY}, 32'd0);
`endif
    run("op12", 4'd12, 32'd5, 32'd3, 32'd0);
    run("op15", 4'd15, 32'hFFFFFFFF, 32'd1, 32'd0);
    run("op10", 4'd10, 32'd8, 32'd8, 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips32_alu.md
Name: mips32_alu

Overview:
- Registered 32-bit integer ALU for the MIPS32 datapath execute stage.
- Computes one of ten arithmetic, logic or shift operations on two operands.
- Presents the result on ALU_OUT one clock after the operands are sampled.
- Driven by the decoder's OPERATOR field; feeds the memory/write-back stage.

Parameters:
- WORD_LEN, 32, operand and result width in bits (shared package constant).
- OPERATOR_LEN, 4, operator select width (shared package constant).

Ports:
- CLK  input  1  system clock; rising-edge active.
- RST_N  input  1  asynchronous, active-low reset.
- OPERAND1  input  WORD_LEN  first operand (A); value to shift for shift ops.
- OPERAND2  input  WORD_LEN  second operand (B); bits [4:0] are the shift amount for shift ops.
- OPERATOR  input  OPERATOR_LEN  operation select.
- ALU_OUT  output  WORD_LEN  registered result.

Interface (already decided): one clock (CLK); reset is asynchronous and active-low (RST_N).

Behaviour:
- Reset: RST_N low forces ALU_OUT = 0 immediately, without waiting for a clock edge. It holds 0 while RST_N is low.
- Reset mid-operation: any pending result is discarded.
- First update: on the first rising CLK edge after RST_N deasserts.
- Latency:
  - Combinational result from the current OPERAND1, OPERAND2 and OPERATOR is captured on each rising CLK edge.
  - ALU_OUT is valid after that edge.
  - Exactly 1 cycle of latency; a new operation is accepted every cycle.
  - No handshake; no stall input.
- Operator encodings (package constants):
  - OPERATOR_ADD=0: A+B, modulo 2^32, wraps silently.
  - OPERATOR_SUB=1: A-B, modulo 2^32 (two's complement).
  - OPERATOR_AND=2: A&B.
  - OPERATOR_OR=3: A|B.
  - OPERATOR_NOR=4: ~(A|B).
  - OPERATOR_XOR=5: A^B.
  - OPERATOR_SLA=6: A shifted left by B[4:0], zero fill. The result is identical to SLL; no saturation, and the sign bit is not preserved.
  - OPERATOR_SLL=7: A logically shifted left by B[4:0], zero fill.
  - OPERATOR_SRA=8: A shifted right by B[4:0], filled with A[31].
  - OPERATOR_SRL=9: A shifted right by B[4:0], zero fill.
  - Codes 10-15: result 0.
- Shift-amount rules:
  - B[31:5] are ignored.
  - Shift by 0 returns A unchanged.
  - Shift by 31 is the maximum.
- Unknown or X operator: treated as an unused code; result 0.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, three extra registered outputs are added. They update on the same edge as ALU_OUT and reset to 0.
  - ZERO (1 bit): set when the result is 0.
  - CARRY (1 bit): carry-out for ADD; borrow-not for SUB (1 when A>=B unsigned); 0 for all other ops.
  - OVERFLOW (1 bit): signed overflow for ADD/SUB; 0 for all other ops.
- When undefined: these ports and registers do not exist, and ALU_OUT behaviour is identical.

Decomposition:
- Shared package/header holds:
  - WORD_LEN and OPERATOR_LEN.
  - All OPERATOR_* encodings listed above.
- One natural sub-module, mips32_alu_shifter:
  - Combinational barrel shifter.
  - Inputs: value, 5-bit amount, 2-bit mode (left, logical right, arithmetic right).
- The top level holds the adder/subtractor, logic ops, result mux and output register.

Test Plan:
- Reset: hold RST_N low, then assert RST_N low mid-stream with ALU_OUT nonzero -> ALU_OUT becomes 0 without a clock edge. After release, the first edge loads the new result.
- A=30, B=10, cycling one op per cycle. Each result must appear one edge after it is applied:
  - ADD -> 40, AND -> 10, NOR -> 0xFFFFFFE1, OR -> 30, XOR -> 20, SUB -> 20.
  - SLA -> 30720, SRA -> 0, SLL -> 30720, SRL -> 0.
- Wrap-around:
  - ADD 0xFFFFFFFF+1 -> 0.
  - SUB 0-1 -> 0xFFFFFFFF.
  - With ALU_FLAGS_EN: ADD 0x7FFFFFFF+1 -> OVERFLOW=1; ADD 0xFFFFFFFF+1 -> ZERO=1, CARRY=1.
- Arithmetic vs logical right shift, A=0x80000000, B=4:
  - SRA -> 0xF8000000.
  - SRL -> 0x08000000.
- Shift boundaries:
  - B=0x00000020: amount 0, SLL -> A unchanged.
  - B=31: SLL of 1 -> 0x80000000.
  - B=31: SRA of 0x80000000 -> 0xFFFFFFFF.
- Unused operator code 12 with A=5, B=3 -> ALU_OUT=0 after the next edge.
